// File: rtl/simple_in_n_out_exerciser.sv
// Purpose: drives all 8 input vectors into a 3-input AND/OR gate and checks its two outputs.
// Latency: SETTLE_CYCLES+2 cycles per vector; done rises 8*(SETTLE_CYCLES+2)+1 cycles after start.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request a run (IDLE or DONE only)
//   drv_1..drv_3      registered gate inputs, drv_{3,2,1} = vec
//   obs_1, obs_2      gate outputs (AND, OR), sampled only in CHECK
//   busy, done, pass  run status
//   err_count         saturating count of failing vectors
//   first_fail_valid  a vector has failed this run
//   first_fail_vec    vec of the first failure
module simple_in_n_out_exerciser #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             drv_1,
  output logic             drv_2,
  output logic             drv_3,
  input  logic             obs_1,
  input  logic             obs_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       exp_1;
  logic       exp_2;
  logic       mismatch;

  // vec is a register, so the gate inputs are glitch-free for the whole
  // vector window; it is 0 in IDLE and parks at 7 in DONE.
  assign drv_1 = vec[0];
  assign drv_2 = vec[1];
  assign drv_3 = vec[2];

  assign exp_1    = &vec;
  assign exp_2    = |vec;
  // A vector counts once even when both outputs are wrong.
  assign mismatch = (obs_1 != exp_1) | (obs_2 != exp_2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        // <= 1 rather than == 1 so a corrupted counter can never stall here.
        if (cnt <= 4'd1) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = (vec == 3'd7) ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
    pass = done && (err_count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec              <= 3'd0;
      cnt              <= 4'd0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Results stay visible in DONE until the next run is requested.
          if (start) begin
            vec              <= 3'd0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 3'd0;
          end
        end
        DRIVE:  cnt <= SETTLE_INIT;
        SETTLE: cnt <= cnt - 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end
          end
          if (vec != 3'd7) vec <= vec + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_in_n_out_exerciser.sv
// Purpose: scoreboard bench for simple_in_n_out_exerciser with a modelled gate.
// Latency: expectations carry the done latency and busy length for each run.
// Backpressure: none; runs are issued back to back once the slowest instance is done.
module tb_simple_in_n_out_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic start = 1'b0;
  int   mode  = 0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate model: 0 correct, 1 out_1 stuck 0, 2 out_2 stuck 1, 3 both inverted.
  function automatic logic [1:0] gate(input logic [2:0] v, input int m);
    logic a;
    logic o;
    a = &v;
    o = |v;
    case (m)
      1: a = 1'b0;
      2: o = 1'b1;
      3: begin a = ~a; o = ~o; end
      default: ;
    endcase
    return {o, a};
  endfunction

  // Instance a: SETTLE 1 / ERR_W 4; b: SETTLE 1 / ERR_W 2; c: SETTLE 0 / ERR_W 4.
  logic       drv_1_a, drv_2_a, drv_3_a, obs_1_a, obs_2_a, busy_a, done_a, pass_a, ffv_a;
  logic [3:0] err_a;
  logic [2:0] ffvec_a;
  logic       drv_1_b, drv_2_b, drv_3_b, obs_1_b, obs_2_b, busy_b, done_b, pass_b, ffv_b;
  logic [1:0] err_b;
  logic [2:0] ffvec_b;
  logic       drv_1_c, drv_2_c, drv_3_c, obs_1_c, obs_2_c, busy_c, done_c, pass_c, ffv_c;
  logic [3:0] err_c;
  logic [2:0] ffvec_c;

  assign {obs_2_a, obs_1_a} = gate({drv_3_a, drv_2_a, drv_1_a}, mode);
  assign {obs_2_b, obs_1_b} = gate({drv_3_b, drv_2_b, drv_1_b}, mode);
  assign {obs_2_c, obs_1_c} = gate({drv_3_c, drv_2_c, drv_1_c}, mode);

  simple_in_n_out_exerciser #(.SETTLE_CYCLES(1), .ERR_W(4)) u_a (
    .clk(clk), .rst(rst), .start(start),
    .drv_1(drv_1_a), .drv_2(drv_2_a), .drv_3(drv_3_a),
    .obs_1(obs_1_a), .obs_2(obs_2_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  simple_in_n_out_exerciser #(.SETTLE_CYCLES(1), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .drv_1(drv_1_b), .drv_2(drv_2_b), .drv_3(drv_3_b),
    .obs_1(obs_1_b), .obs_2(obs_2_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  simple_in_n_out_exerciser #(.SETTLE_CYCLES(0), .ERR_W(4)) u_c (
    .clk(clk), .rst(rst), .start(start),
    .drv_1(drv_1_c), .drv_2(drv_2_c), .drv_3(drv_3_c),
    .obs_1(obs_1_c), .obs_2(obs_2_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c)
  );

  typedef struct {
    int err;
    int ffv;
    int ffvec;
    int pass;
    int lat;
    int run_start;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // Hand-derived results for each gate fault.
  function automatic exp_t mk(input int m, input int errw, input int lat, input int rs);
    exp_t e;
    e.lat = lat;
    e.run_start = rs;
    case (m)
      1:       begin e.err = 1; e.ffv = 1; e.ffvec = 7; e.pass = 0; end
      2:       begin e.err = 1; e.ffv = 1; e.ffvec = 0; e.pass = 0; end
      3:       begin e.err = (errw == 2) ? 3 : 8; e.ffv = 1; e.ffvec = 0; e.pass = 0; end
      default: begin e.err = 0; e.ffv = 0; e.ffvec = 0; e.pass = 1; end
    endcase
    return e;
  endfunction

  bit prev_done[3];
  int bcnt[3];

  task automatic mon(input int i, input logic dn, input logic bz, input logic ps,
                     input int er, input logic fv, input logic [2:0] fvec, input logic [2:0] drv);
    exp_t e;
    bit   have;
    string s;
    have = 1'b0;
    if (rst) begin
      bcnt[i] = 0;
      prev_done[i] = 1'b0;
      return;
    end
    if (bz) bcnt[i]++;
    if (dn && !prev_done[i]) begin
      case (i)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      s = $sformatf("_%0d", i);
      if (!have) begin
        chk({"unexpected_done", s}, 1, 0);
      end else begin
        chk({"err_count", s}, er, e.err);
        chk({"first_fail_valid", s}, int'(fv), e.ffv);
        chk({"first_fail_vec", s}, int'(fvec), e.ffvec);
        chk({"pass", s}, int'(ps), e.pass);
        chk({"done_latency", s}, cyc - e.run_start, e.lat);
        chk({"busy_cycles", s}, bcnt[i], e.lat - 1);
        chk({"drv_in_done", s}, int'(drv), 7);
      end
      bcnt[i] = 0;
    end
    prev_done[i] = dn;
  endtask

  always @(negedge clk) begin
    mon(0, done_a, busy_a, pass_a, int'(err_a), ffv_a, ffvec_a, {drv_3_a, drv_2_a, drv_1_a});
    mon(1, done_b, busy_b, pass_b, int'(err_b), ffv_b, ffvec_b, {drv_3_b, drv_2_b, drv_1_b});
    mon(2, done_c, busy_c, pass_c, int'(err_c), ffv_c, ffvec_c, {drv_3_c, drv_2_c, drv_1_c});
  end

  task automatic zchk(input string t, input logic d, input logic b, input logic p, input int e,
                      input logic fv, input logic [2:0] fvec, input logic [2:0] drv);
    chk({"zero_done_", t}, int'(d), 0);
    chk({"zero_busy_", t}, int'(b), 0);
    chk({"zero_pass_", t}, int'(p), 0);
    chk({"zero_err_", t}, e, 0);
    chk({"zero_ffv_", t}, int'(fv), 0);
    chk({"zero_ffvec_", t}, int'(fvec), 0);
    chk({"zero_drv_", t}, int'(drv), 0);
  endtask

  task automatic zchk_all();
    zchk("a", done_a, busy_a, pass_a, int'(err_a), ffv_a, ffvec_a, {drv_3_a, drv_2_a, drv_1_a});
    zchk("b", done_b, busy_b, pass_b, int'(err_b), ffv_b, ffvec_b, {drv_3_b, drv_2_b, drv_1_b});
    zchk("c", done_c, busy_c, pass_c, int'(err_c), ffv_c, ffvec_c, {drv_3_c, drv_2_c, drv_1_c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
  endtask

  // Issue one run: start pulses in cycle 0; optional start toggling while busy.
  task automatic run(input int m, input bit toggle);
    int rs;
    mode = m;
    rs = cyc;
    q0.push_back(mk(m, 4, 25, rs));
    q1.push_back(mk(m, 2, 25, rs));
    q2.push_back(mk(m, 4, 17, rs));
    start = 1'b1;
    tick();
    start = 1'b0;
    if (toggle) begin
      for (int k = 0; k < 9; k++) begin
        tick();
        start = ~start;
      end
      start = 1'b0;
    end
    wait_done_a();
  endtask

  initial begin
    int rs;
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    zchk_all();
    start = 1'b0;
    rst = 1'b0;
    tick();

    run(0, 1'b0);  // correct gate
    run(1, 1'b0);  // out_1 stuck at 0
    run(2, 1'b0);  // out_2 stuck at 1
    run(3, 1'b0);  // both inverted, saturates in instance b
    run(0, 1'b0);  // start from DONE clears previous failures
    run(0, 1'b1);  // start toggled while busy
    run(0, 1'b0);  // repeat run gives identical results

    // Reset in cycle 10 of a failing run.
    mode = 3;
    rs = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc - rs < 10) tick();
    rst = 1'b1;
    tick();
    zchk_all();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("no_done_after_reset", int'(done_a), 0);

    run(0, 1'b0);  // clean run after reset

    for (int k = 0; k < 3; k++) tick();
    chk("queue_empty_a", q0.size(), 0);
    chk("queue_empty_b", q1.size(), 0);
    chk("queue_empty_c", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
